// File: rtl/regfile_param.sv
// Parameterised register file with one write port, two combinational read ports,
// a hardwired zero register and a one-register-per-cycle clear sweep.
module regfile_param #(
  parameter int WIDTH    = 64,
  parameter int NREG     = 32,
  parameter int ZERO_REG = NREG - 1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [$clog2(NREG)-1:0]  waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(NREG)-1:0]  raddr1,
  input  logic [$clog2(NREG)-1:0]  raddr2,
  output logic [WIDTH-1:0]         rdata1,
  output logic [WIDTH-1:0]         rdata2,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  regs_q [NREG];
  logic [WIDTH-1:0]  regs_d [NREG];
  logic              waddr_ok;
  logic              wr_valid;

  // A write only counts when it targets real storage and no sweep owns the file.
  always_comb begin
    waddr_ok = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (i != ZERO_REG && waddr == AW'(i)) begin
        waddr_ok = 1'b1;
      end
    end
    wr_valid = we && (state_q == IDLE) && waddr_ok;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    clr_busy = (state_q == CLEAR);
    clr_done = (state_q == DONE);
  end

  // The zero register's slot is forced to 0 every cycle, so it reduces to a constant.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_valid && waddr == AW'(i)) begin
        regs_d[i] = wdata;
      end
      if (state_q == CLEAR && idx_q == AW'(i)) begin
        regs_d[i] = '0;
      end
      if (i == ZERO_REG) begin
        regs_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // wr_valid is never set during a sweep, so forwarding is off there automatically.
  always_comb begin
    rdata1 = '0;
    for (int i = 0; i < NREG; i++) begin
      if (i != ZERO_REG && raddr1 == AW'(i)) begin
        rdata1 = regs_q[i];
      end
    end
    if (BYPASS && wr_valid && waddr == raddr1) begin
      rdata1 = wdata;
    end
  end

  always_comb begin
    rdata2 = '0;
    for (int i = 0; i < NREG; i++) begin
      if (i != ZERO_REG && raddr2 == AW'(i)) begin
        rdata2 = regs_q[i];
      end
    end
    if (BYPASS && wr_valid && waddr == raddr2) begin
      rdata2 = wdata;
    end
  end

endmodule
